// File: rtl/regfile_pkg.sv
// Shared FSM state type and default sizes for the multi-port register file.
package regfile_pkg;

    typedef enum logic {
        CLEAR = 1'b0,
        READY = 1'b1
    } state_e;

    localparam int XLEN_DEF  = 32;
    localparam int NREGS_DEF = 32;
    localparam int NRD_DEF   = 2;

endpackage

// File: rtl/regfile_rdport.sv
// One combinational read port: zero-masks x0 and sweep time, optionally forwards the write.
// Optional feature: REGFILE_BYPASS_EN adds same-cycle write forwarding.
module regfile_rdport
    import regfile_pkg::*;
#(
    parameter int XLEN = XLEN_DEF,
    parameter int AW   = 5
) (
    input  logic [AW-1:0]   i_addr,
    input  logic            i_busy,
    input  logic [XLEN-1:0] i_reg_data,
`ifdef REGFILE_BYPASS_EN
    input  logic            i_byp_vld,
    input  logic [AW-1:0]   i_byp_addr,
    input  logic [XLEN-1:0] i_byp_data,
`endif
    output logic [XLEN-1:0] o_data
);

    always_comb begin
        if (i_busy || i_addr == '0) begin
            o_data = '0;
        end
`ifdef REGFILE_BYPASS_EN
        else if (i_byp_vld && i_byp_addr == i_addr) begin
            o_data = i_byp_data;
        end
`endif
        else begin
            o_data = i_reg_data;
        end
    end

endmodule

// File: rtl/regfile_mp.sv
// Multi-read-port register file with x0 hardwired to zero and a zeroing sweep after reset/clear.
// Optional feature: REGFILE_BYPASS_EN forwards an accepted write to matching read ports.
module regfile_mp
    import regfile_pkg::*;
#(
    parameter int  XLEN  = XLEN_DEF,
    parameter int  NREGS = NREGS_DEF,
    parameter int  NRD   = NRD_DEF,
    localparam int AW    = $clog2(NREGS)
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic [NRD*AW-1:0] i_rd_addr,
    output logic [NRD*XLEN-1:0] o_rd_data,
    input  logic              i_we,
    input  logic [AW-1:0]     i_wr_addr,
    input  logic [XLEN-1:0]   i_wr_data,
    input  logic              i_clr_req,
    output logic              o_busy,
    output logic              o_wr_err,
    output state_e            o_dbg_state
);

    state_e          state_q, state_d;
    logic [AW-1:0]   clr_idx_q, clr_idx_d;
    logic            wr_err_q, wr_err_d;
    logic [XLEN-1:0] regs_q [NREGS];
    logic            wr_fire;

    // Write handshake: i_we is a request without backpressure. It is accepted only in
    // READY with i_clr_req low; any other request is dropped and flagged on o_wr_err next cycle.
    assign wr_fire  = (state_q == READY) && i_we && !i_clr_req && (i_wr_addr != '0);
    assign wr_err_d = i_we && ((state_q == CLEAR) || i_clr_req);

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q <= CLEAR;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        clr_idx_d = clr_idx_q;
        case (state_q)
            CLEAR: begin
                clr_idx_d = clr_idx_q + AW'(1);
                if (clr_idx_q == AW'(NREGS - 1)) begin
                    state_d = READY;
                end
            end
            READY: begin
                if (i_clr_req) begin
                    state_d   = CLEAR;
                    clr_idx_d = AW'(1);
                end
            end
        endcase
    end

    always_comb begin
        o_busy      = (state_q == CLEAR);
        o_wr_err    = wr_err_q;
        o_dbg_state = state_q;
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            clr_idx_q <= AW'(1);
            wr_err_q  <= 1'b0;
        end else begin
            clr_idx_q <= clr_idx_d;
            wr_err_q  <= wr_err_d;
        end
    end

    // The array has no reset; zeroing comes only from the sweep. Entry 0 is never read.
    always_ff @(posedge i_clk) begin
        if (state_q == CLEAR) begin
            regs_q[clr_idx_q] <= '0;
        end else if (wr_fire) begin
            regs_q[i_wr_addr] <= i_wr_data;
        end
    end

    for (genvar k = 0; k < NRD; k++) begin : g_rd
        logic [AW-1:0] addr;
        assign addr = i_rd_addr[k*AW +: AW];

        regfile_rdport #(
            .XLEN (XLEN),
            .AW   (AW)
        ) u_rdport (
            .i_addr     (addr),
            .i_busy     (o_busy),
            .i_reg_data (regs_q[addr]),
`ifdef REGFILE_BYPASS_EN
            .i_byp_vld  (wr_fire),
            .i_byp_addr (i_wr_addr),
            .i_byp_data (i_wr_data),
`endif
            .o_data     (o_rd_data[k*XLEN +: XLEN])
        );
    end

endmodule

// File: tb/tb_regfile_mp.sv
// Bench for regfile_mp: directed scenarios plus random traffic against an array model,
// and a second 4-port/64-bit/16-entry instance.
module tb_regfile_mp;
    import regfile_pkg::*;

    localparam int XLEN  = 32;
    localparam int NREGS = 32;
    localparam int NRD   = 2;
    localparam int AW    = 5;
    localparam int XLEN4  = 64;
    localparam int NREGS4 = 16;
    localparam int NRD4   = 4;
    localparam int AW4    = 4;

    // ---------------- clock / reset ----------------
    logic i_clk   = 1'b0;
    logic i_rst_n = 1'b1;
    always #5 i_clk = ~i_clk;

    // ---------------- main instance ----------------
    logic [AW-1:0]       rd_a [NRD];
    logic [NRD*AW-1:0]   i_rd_addr;
    logic [NRD*XLEN-1:0] o_rd_data;
    logic                i_we;
    logic [AW-1:0]       i_wr_addr;
    logic [XLEN-1:0]     i_wr_data;
    logic                i_clr_req;
    logic                o_busy;
    logic                o_wr_err;
    state_e              o_dbg_state;

    assign i_rd_addr = {rd_a[1], rd_a[0]};

    regfile_mp #(.XLEN(XLEN), .NREGS(NREGS), .NRD(NRD)) dut (
        .i_clk       (i_clk),
        .i_rst_n     (i_rst_n),
        .i_rd_addr   (i_rd_addr),
        .o_rd_data   (o_rd_data),
        .i_we        (i_we),
        .i_wr_addr   (i_wr_addr),
        .i_wr_data   (i_wr_data),
        .i_clr_req   (i_clr_req),
        .o_busy      (o_busy),
        .o_wr_err    (o_wr_err),
        .o_dbg_state (o_dbg_state)
    );

    // ---------------- wide instance ----------------
    logic [NRD4*AW4-1:0]   b_rd_addr;
    logic [NRD4*XLEN4-1:0] b_rd_data;
    logic                  b_we;
    logic [AW4-1:0]        b_wa;
    logic [XLEN4-1:0]      b_wd;
    logic                  b_clr;
    logic                  b_busy;
    logic                  b_err;
    state_e                b_state;

    regfile_mp #(.XLEN(XLEN4), .NREGS(NREGS4), .NRD(NRD4)) dut4 (
        .i_clk       (i_clk),
        .i_rst_n     (i_rst_n),
        .i_rd_addr   (b_rd_addr),
        .o_rd_data   (b_rd_data),
        .i_we        (b_we),
        .i_wr_addr   (b_wa),
        .i_wr_data   (b_wd),
        .i_clr_req   (b_clr),
        .o_busy      (b_busy),
        .o_wr_err    (b_err),
        .o_dbg_state (b_state)
    );

    // ---------------- scoreboard / reference model ----------------
    int checks   = 0;
    int failures = 0;
    logic [XLEN-1:0]  mem [NREGS];
    int               sweep_left;
    logic             err_exp;
    logic [XLEN4-1:0] exp_q [$];

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        sweep_left = NREGS - 1;
        err_exp    = 1'b0;
    endtask

    // Register-level behaviour at one rising edge, using the inputs held across it.
    task automatic model_edge();
        if (sweep_left > 0) begin
            err_exp = i_we;
            sweep_left--;
            if (sweep_left == 0) begin
                foreach (mem[i]) mem[i] = '0;
            end
        end else begin
            err_exp = i_we && i_clr_req;
            if (i_clr_req) begin
                sweep_left = NREGS - 1;
            end else if (i_we && i_wr_addr != '0) begin
                mem[i_wr_addr] = i_wr_data;
            end
        end
    endtask

    function automatic logic [XLEN-1:0] exp_rd(input logic [AW-1:0] a);
        if (sweep_left > 0 || a == '0) return '0;
`ifdef REGFILE_BYPASS_EN
        if (i_we && !i_clr_req && i_wr_addr == a) return i_wr_data;
`endif
        return mem[a];
    endfunction

    task automatic check_model(input string tag);
        for (int k = 0; k < NRD; k++) begin
            chk($sformatf("%s.rd%0d", tag, k), 64'(o_rd_data[k*XLEN +: XLEN]), 64'(exp_rd(rd_a[k])));
        end
        chk({tag, ".busy"}, 64'(o_busy), 64'(sweep_left > 0));
        chk({tag, ".wr_err"}, 64'(o_wr_err), 64'(err_exp));
        chk({tag, ".state"}, 64'(o_dbg_state), 64'((sweep_left > 0) ? CLEAR : READY));
    endtask

    // ---------------- driver tasks ----------------
    task automatic drive(input logic we_v, input logic [AW-1:0] wa_v, input logic [XLEN-1:0] wd_v,
                         input logic clr_v, input logic [AW-1:0] r0_v, input logic [AW-1:0] r1_v);
        i_we      = we_v;
        i_wr_addr = wa_v;
        i_wr_data = wd_v;
        i_clr_req = clr_v;
        rd_a[0]   = r0_v;
        rd_a[1]   = r1_v;
    endtask

    // Called just after a falling edge with inputs set; checks, then advances one clock.
    task automatic cycle(input string tag);
        #1;
        check_model(tag);
        @(posedge i_clk);
        if (i_rst_n) model_edge();
        @(negedge i_clk);
    endtask

    // ---------------- stimulus ----------------
    int               n;
    int               pulses;
    logic [AW-1:0]    wa_r;
    logic [XLEN4-1:0] b_val;
    logic [XLEN4-1:0] exp_v;

    initial begin
        drive(0, '0, '0, 0, '0, '0);
        b_we = 1'b0; b_wa = '0; b_wd = '0; b_clr = 1'b0; b_rd_addr = '0;
        model_reset();
        #2 i_rst_n = 1'b0;
        repeat (2) @(negedge i_clk);
        cycle("reset");

        // Sweep after reset release, then every address reads zero.
        i_rst_n = 1'b1;
        n = 0;
        while (o_busy === 1'b1 && n < 100) begin cycle("sweep"); n++; end
        chk("sweep_len", 64'(n), 64'd31);
        for (int a = 0; a < NREGS; a += 2) begin
            drive(0, '0, '0, 0, AW'(a), AW'(a + 1));
            #1;
            chk($sformatf("zero_x%0d", a), 64'(o_rd_data[XLEN-1:0]), 64'h0);
            cycle("zero");
        end

        // Write x5 and a discarded write to x0.
        drive(1, 5'd5, 32'hDEADBEEF, 0, '0, '0); cycle("w5");
        drive(1, 5'd0, 32'h12345678, 0, '0, '0); cycle("w0");
        drive(0, '0, '0, 0, 5'd5, 5'd0);
        #1;
        chk("x5_rd0", 64'(o_rd_data[31:0]), 64'hDEADBEEF);
        chk("x0_rd1", 64'(o_rd_data[63:32]), 64'h0);
        chk("x0_no_err", 64'(o_wr_err), 64'h0);
        cycle("r5");

        // Same-cycle read of a register being written.
        drive(1, 5'd7, 32'h0BAD0007, 0, '0, '0); cycle("w7a");
        drive(1, 5'd7, 32'hCAFEF00D, 0, '0, 5'd7);
        #1;
`ifdef REGFILE_BYPASS_EN
        chk("x7_same_cycle", 64'(o_rd_data[63:32]), 64'hCAFEF00D);
`else
        chk("x7_same_cycle", 64'(o_rd_data[63:32]), 64'h0BAD0007);
`endif
        cycle("w7b");
        drive(0, '0, '0, 0, 5'd7, 5'd7);
        #1;
        chk("x7_next_cycle", 64'(o_rd_data[31:0]), 64'hCAFEF00D);
        cycle("r7");

        // Clear request, then a rejected write during the sweep.
        drive(1, 5'd3, 32'hA5A5A5A5, 0, 5'd3, 5'd3); cycle("w3");
        drive(0, '0, '0, 1, 5'd3, 5'd3);
        #1;
        chk("x3_before_clr", 64'(o_rd_data[31:0]), 64'hA5A5A5A5);
        cycle("clr");
        drive(1, 5'd3, 32'h33333333, 0, 5'd3, 5'd3);
        #1;
        chk("clr_busy", 64'(o_busy), 64'h1);
        chk("clr_rd_zero", 64'(o_rd_data[31:0]), 64'h0);
        cycle("w3_busy");
        drive(0, '0, '0, 0, 5'd3, 5'd3);
        n = 0; pulses = 0;
        while (o_busy === 1'b1 && n < 100) begin
            #1;
            if (o_wr_err === 1'b1) pulses++;
            cycle("sweep2");
            n++;
        end
        chk("sweep2_rest", 64'(n), 64'd30);
        chk("busy_wr_err_pulses", 64'(pulses), 64'd1);
        #1;
        chk("x3_cleared", 64'(o_rd_data[31:0]), 64'h0);
        cycle("r3");

        // Write and clear in the same cycle.
        drive(1, 5'd9, 32'h99999999, 1, 5'd9, 5'd0); cycle("we_clr");
        drive(0, '0, '0, 0, 5'd9, 5'd0);
        #1;
        chk("we_clr_err", 64'(o_wr_err), 64'h1);
        chk("we_clr_busy", 64'(o_busy), 64'h1);
        n = 0;
        while (o_busy === 1'b1 && n < 100) begin cycle("sweep3"); n++; end
        #1;
        chk("x9_dropped", 64'(o_rd_data[31:0]), 64'h0);
        cycle("r9");

        // Reset in READY, then again mid-sweep at index 10.
        i_rst_n = 1'b0; model_reset(); cycle("rst2");
        i_rst_n = 1'b1;
        repeat (9) cycle("pre_mid");
        i_rst_n = 1'b0; model_reset();
        #1;
        chk("mid_rst_busy", 64'(o_busy), 64'h1);
        cycle("mid_rst");
        i_rst_n = 1'b1;
        n = 0;
        while (o_busy === 1'b1 && n < 100) begin cycle("restart"); n++; end
        chk("restart_len", 64'(n), 64'd31);

        // Random traffic.
        for (int i = 0; i < 400; i++) begin
            wa_r = AW'($urandom_range(0, NREGS - 1));
            drive(1'($urandom_range(0, 1)), wa_r, $urandom, ($urandom_range(0, 99) < 3),
                  ($urandom_range(0, 3) == 0) ? wa_r : AW'($urandom_range(0, NREGS - 1)),
                  ($urandom_range(0, 3) == 0) ? wa_r : AW'($urandom_range(0, NREGS - 1)));
            cycle("rand");
        end

        // Wide instance: 16-entry sweep, then four ports read four distinct values.
        drive(0, '0, '0, 0, '0, '0);
        i_rst_n = 1'b0;
        repeat (2) @(negedge i_clk);
        i_rst_n = 1'b1;
        n = 0;
        while (b_busy === 1'b1 && n < 100) begin @(posedge i_clk); @(negedge i_clk); n++; end
        chk("sweep16_len", 64'(n), 64'd15);
        for (int k = 1; k <= 4; k++) begin
            b_val = {$urandom, $urandom};
            exp_q.push_back(b_val);
            b_we = 1'b1; b_wa = AW4'(k); b_wd = b_val;
            @(posedge i_clk); @(negedge i_clk);
        end
        b_we = 1'b0;
        b_rd_addr = {4'd4, 4'd3, 4'd2, 4'd1};
        #1;
        for (int k = 0; k < NRD4; k++) begin
            exp_v = exp_q.pop_front();
            chk($sformatf("wide_rd%0d", k), b_rd_data[k*XLEN4 +: XLEN4], exp_v);
        end
        chk("wide_no_err", 64'(b_err), 64'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/regfile_mp.md
REGFILE_MP -- requirements
Module: regfile_mp

Interface
REQ-001 SHALL have parameter XLEN, default 32, data width in bits.
REQ-002 SHALL have parameter NREGS, default 32, register count; power of two, >= 2; AW = clog2(NREGS).
REQ-003 SHALL have parameter NRD, default 2, number of combinational read ports, >= 1.
REQ-004 SHALL have port i_clk  input  1  the single clock; all state updates on its rising edge.
REQ-005 SHALL have port i_rst_n  input  1  asynchronous, active-low reset.
REQ-006 SHALL have port i_rd_addr  input  NRD*AW  packed read addresses; port k in bits [k*AW +: AW].
REQ-007 SHALL have port o_rd_data  output  NRD*XLEN  packed read data; port k in bits [k*XLEN +: XLEN].
REQ-008 SHALL have port i_we  input  1  write request.
REQ-009 SHALL have port i_wr_addr  input  AW  write address.
REQ-010 SHALL have port i_wr_data  input  XLEN  write data.
REQ-011 SHALL have port i_clr_req  input  1  request a full zeroing sweep.
REQ-012 SHALL have port o_busy  output  1  high while a sweep is in progress.
REQ-013 SHALL have port o_wr_err  output  1  one-cycle pulse: a write was rejected.

Function
REQ-014 SHALL implement a two-state FSM, CLEAR and READY, with a sweep counter clr_idx of width AW.
REQ-015 In CLEAR, each cycle SHALL write zero to registers[clr_idx] and increment clr_idx; on the edge where clr_idx == NREGS-1, the FSM SHALL write that entry and go to READY.
REQ-016 The sweep SHALL start at index 1 and SHALL last exactly NREGS-1 cycles; o_busy SHALL equal (state == CLEAR).
REQ-017 In READY, i_clr_req high SHALL move the FSM to CLEAR with clr_idx = 1 on the next edge; i_clr_req SHALL be ignored in CLEAR.
REQ-018 In READY, i_we high with i_wr_addr != 0 SHALL write i_wr_data to registers[i_wr_addr] at the edge.
REQ-019 If i_we and i_clr_req are high in the same READY cycle, the write SHALL be dropped, the sweep SHALL start, and o_wr_err SHALL pulse.
REQ-020 A write with i_wr_addr == 0 SHALL be discarded silently, with no error.
REQ-021 i_we high while o_busy is high SHALL be discarded, and o_wr_err SHALL be high in the following cycle for one cycle.
REQ-022 Read port k SHALL return 0 when its address is 0 or when o_busy is high; otherwise it SHALL return registers[addr], combinationally.
REQ-023 Read ports SHALL be independent; any number of ports MAY read the same address in the same cycle.

Reset
REQ-024 Asserting i_rst_n low SHALL immediately set state = CLEAR, clr_idx = 1, o_wr_err = 0, and o_busy = 1.
REQ-025 The register array SHALL NOT be asynchronously reset; its zeroing SHALL come only from the sweep.
REQ-026 A reset during a sweep or during READY SHALL restart the sweep from index 1.
REQ-027 o_rd_data SHALL read all zeros from reset assertion until the sweep completes.

Configuration
REQ-028 With macro REGFILE_BYPASS_EN defined, a READY-state write to address A != 0 SHALL be forwarded combinationally to every read port addressing A in the same cycle, returning i_wr_data.
REQ-029 Without REGFILE_BYPASS_EN, read ports SHALL return the pre-edge register contents, and new data SHALL be visible the cycle after the write.
REQ-030 Rejected writes (REQ-019, REQ-021) SHALL never be forwarded, in either configuration.

Structure
REQ-031 Package regfile_pkg SHALL hold the FSM state typedef (CLEAR, READY) and the default parameter constants XLEN_DEF, NREGS_DEF and NRD_DEF.
REQ-032 One sub-module regfile_rdport SHALL implement a single read port, including the zero-masking and bypass mux; it SHALL be instantiated NRD times via generate.
REQ-033 The array, FSM and write logic SHALL stay in regfile_mp.

Verification
REQ-034 Reset release, NREGS=32: o_busy SHALL stay high for exactly 31 cycles, then drop; every address SHALL then read 0x00000000.
REQ-035 Writes 0xDEADBEEF to x5 and 0x12345678 to x0, reading x5/x0 on ports 0/1 the next cycle: ports SHALL return 0xDEADBEEF / 0x00000000, and o_wr_err SHALL stay 0.
REQ-036 Write 0xCAFEF00D to x7 while port 1 reads x7 in the same cycle: port 1 SHALL return 0xCAFEF00D with REGFILE_BYPASS_EN, and the old value without it.
REQ-037 i_clr_req pulse after x3 = 0xA5A5A5A5, then a write to x3 during the sweep: o_wr_err SHALL pulse once, reads SHALL return 0 during the sweep, and x3 SHALL read 0 after o_busy falls.
REQ-038 i_rst_n low mid-sweep, at clr_idx = 10: o_busy SHALL stay high, and the sweep SHALL restart, completing 31 cycles after reset release.
REQ-039 NRD=4, XLEN=64, NREGS=16: four ports reading x1..x4 after distinct writes SHALL each return their own value; the sweep SHALL last 15 cycles.
